// File: rtl/logic_gate_fifo.sv
// ============================================================================
// logic_gate_fifo
// ----------------------------------------------------------------------------
// This block is a WIDTH-bit bitwise logic unit followed by a DEPTH-entry result
// buffer. The operation is selected for each transaction. Operand pairs arrive
// on a valid/ready handshake. Each result is computed in the cycle it is
// accepted and is stored together with its zero flag and its parity bit. The
// consumer drains the buffer through a second valid/ready handshake. Because
// every result is stored, a stalled consumer never causes a result to be lost.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   in_valid   : producer presents a, b and op this cycle
//   in_ready   : buffer has room; depends on registered state only
//   a, b       : WIDTH-bit operands
//   op         : 3-bit operation select
//   out_valid  : buffer head holds a result
//   out_ready  : consumer takes the head result this cycle
//   y          : result at the buffer head
//   y_zero     : head result equals zero
//   y_par      : XOR-reduction of the head result
//   level      : number of entries currently held (0..DEPTH)
// ============================================================================
module logic_gate_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [2:0]               op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         y,
    output logic                     y_zero,
    output logic                     y_par,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_NOTA = 3'b110,
        OP_ANDN = 3'b111
    } opSel_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [WIDTH-1:0] dataMem_q [DEPTH];
    logic [DEPTH-1:0] zeroMem_q;
    logic [DEPTH-1:0] parMem_q;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] opResult;
    logic             opZero;
    logic             opPar;
    logic             fullFlag;
    logic             emptyFlag;
    logic             pushEn;
    logic             popEn;
    logic [AW-1:0]    wrIdx;
    logic [AW-1:0]    rdIdx;

    assign wrIdx = wrPtr_q[AW-1:0];
    assign rdIdx = rdPtr_q[AW-1:0];

    // The pointers carry one extra wrap bit. Equal low bits with differing
    // wrap bits means the writer is exactly one lap ahead of the reader.
    assign fullFlag  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) &&
                       (wrPtr_q[AW] != rdPtr_q[AW]);
    assign emptyFlag = (wrPtr_q == rdPtr_q);

    // The pop does not free a slot for a push in the same cycle. This keeps
    // in_ready free of any combinational path from out_ready.
    assign pushEn = in_valid && !fullFlag;
    assign popEn  = !emptyFlag && out_ready;

    // ------------------------------------------------------------------------
    // Operation decode. The result and its flags are computed in the push
    // cycle and stored, so the output side never recomputes them.
    // ------------------------------------------------------------------------
    always_comb begin
        opResult = '0;
        case (opSel_e'(op))
            OP_AND:  opResult = a & b;
            OP_OR:   opResult = a | b;
            OP_XOR:  opResult = a ^ b;
            OP_NAND: opResult = ~(a & b);
            OP_NOR:  opResult = ~(a | b);
            OP_XNOR: opResult = ~(a ^ b);
            OP_NOTA: opResult = ~a;
            OP_ANDN: opResult = a & ~b;
            default: opResult = '0;
        endcase
    end

    assign opZero = (opResult == '0);
    assign opPar  = ^opResult;

    // ------------------------------------------------------------------------
    // Pointer next-state
    // ------------------------------------------------------------------------
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Result storage. Every entry is cleared on reset, so y, y_zero and y_par
    // read as zero immediately after reset. This holds even though the read
    // path is not gated by out_valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dataMem_q[i] <= '0;
            end
            zeroMem_q <= '0;
            parMem_q  <= '0;
        end else if (pushEn) begin
            dataMem_q[wrIdx] <= opResult;
            zeroMem_q[wrIdx] <= opZero;
            parMem_q[wrIdx]  <= opPar;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. All of them are functions of registered state only. The head
    // entry is written only when the buffer wraps onto it, and that cannot
    // happen while the entry is still unread. The head data therefore stays
    // stable until the edge on which it is popped.
    // ------------------------------------------------------------------------
    assign in_ready  = !fullFlag;
    assign out_valid = !emptyFlag;
    assign y         = dataMem_q[rdIdx];
    assign y_zero    = zeroMem_q[rdIdx];
    assign y_par     = parMem_q[rdIdx];
    assign level     = wrPtr_q - rdPtr_q;

endmodule
